// File: rtl/memory1_pkg.sv
// Shared constants and access encoding for the memory1 single-port RAM.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package memory1_pkg;

   localparam int MEM_DW_DEF    = 16;
   localparam int MEM_AW_DEF    = 25;
   localparam int MEM_DEPTH_DEF = 256;

   // Kind of access decoded from cs/wen for the current cycle.
   typedef enum logic [1:0] {
      ACC_NONE = 2'd0,
      ACC_RD   = 2'd1,
      ACC_WR   = 2'd2
   } access_e;

endpackage

// File: rtl/memory1_array.sv
// Raw storage array: one write port and one registered read port sharing an index.
// Latency: read data appears 1 cycle after rd_en is sampled; writes land on the same edge.
// Backpressure: none; one access per clock, the caller guarantees rd_en and wr_en are exclusive.
// Ports: clk, rst (async active-high, clears read register only), wr_en, rd_en,
//        idx (word index), wdata (write data), rdata (registered read data).
module memory1_array #(
   parameter int DW    = 16,
   parameter int DEPTH = 256,
   parameter int IW    = 8
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          wr_en,
   input  logic          rd_en,
   input  logic [IW-1:0] idx,
   input  logic [DW-1:0] wdata,
   output logic [DW-1:0] rdata
);

   logic [DW-1:0] mem_q [DEPTH];
   logic [DW-1:0] rd_d;
   logic [DW-1:0] rd_q;

   // Read register only moves on a read; it holds through writes and idle cycles.
   always_comb begin
      rd_d = rd_q;
      if (rd_en) begin
         rd_d = mem_q[idx];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_q <= '0;
      end else begin
         rd_q <= rd_d;
      end
   end

   // Storage is intentionally not reset.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem_q[idx] <= wdata;
      end
   end

   assign rdata = rd_q;

endmodule

// File: rtl/memory1.sv
// Single-port synchronous RAM wrapper: address truncation, access qualification and reset.
// Latency: 1-cycle read; write takes effect on the sampling edge.
// Backpressure: none; an access may be issued every cycle with no handshake.
// Ports: clk, rst (async active-high), cs (chip select), wen (1=write, 0=read),
//        addr (word address, aliased modulo DEPTH), wdata, rdata (registered read data).
module memory1
   import memory1_pkg::*;
#(
   parameter int DW    = MEM_DW_DEF,
   parameter int AW    = MEM_AW_DEF,
   parameter int DEPTH = MEM_DEPTH_DEF
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          cs,
   input  logic          wen,
   input  logic [AW-1:0] addr,
   input  logic [DW-1:0] wdata,
   output logic [DW-1:0] rdata
);

   // DEPTH is a power of two (>= 2), so the low IW address bits select the word.
   localparam int IW = $clog2(DEPTH);

   access_e       acc;
   logic          wr_en;
   logic          rd_en;
   logic [IW-1:0] idx;

   // Nested ifs with a no-access default: an unknown cs or wen never
   // satisfies either branch, so it decodes as no access. Reset gates both
   // ports combinationally, which also drops a write pending when rst rises.
   always_comb begin
      acc = ACC_NONE;
      if (!rst) begin
         if (cs) begin
            if (wen) begin
               acc = ACC_WR;
            end else if (!wen) begin
               acc = ACC_RD;
            end
         end
      end
   end

   assign wr_en = (acc == ACC_WR);
   assign rd_en = (acc == ACC_RD);
   assign idx   = addr[IW-1:0];

   // Upper address bits are deliberately ignored (aliasing).
   generate
      if (AW > IW) begin : g_unused_addr
         logic unused_addr_bits;
         assign unused_addr_bits = ^addr[AW-1:IW];
      end
   endgenerate

   memory1_array #(
      .DW    (DW),
      .DEPTH (DEPTH),
      .IW    (IW)
   ) u_array (
      .clk   (clk),
      .rst   (rst),
      .wr_en (wr_en),
      .rd_en (rd_en),
      .idx   (idx),
      .wdata (wdata),
      .rdata (rdata)
   );

endmodule

// File: tb/tb_memory1.sv
module tb_memory1;

   logic        clk;
   logic        rst;
   logic        cs;
   logic        wen;
   logic [24:0] addr;
   logic [15:0] wdata;
   logic [15:0] rdata;

   int checks   = 0;
   int failures = 0;

   logic [15:0] words [24];
   logic [15:0] prev;

   memory1 dut (
      .clk   (clk),
      .rst   (rst),
      .cs    (cs),
      .wen   (wen),
      .addr  (addr),
      .wdata (wdata),
      .rdata (rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Present one access at the falling edge, let the rising edge sample it,
   // then return 1 time unit after that edge so outputs can be checked.
   task automatic acc(input logic c, input logic w, input logic [24:0] a, input logic [15:0] d);
      @(negedge clk);
      cs    = c;
      wen   = w;
      addr  = a;
      wdata = d;
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst   = 1'b0;
      cs    = 1'b0;
      wen   = 1'b0;
      addr  = '0;
      wdata = '0;
      #1 rst = 1'b1;
      #1;
      chk("reset_async", rdata, 16'h0000);

      // Access attempted while in reset is blocked.
      acc(1'b1, 1'b1, 25'd9, 16'hDEAD);
      acc(1'b1, 1'b0, 25'd9, 16'h0000);
      chk("reset_blocks_read", rdata, 16'h0000);

      // Release reset; the access presented at the next edge is performed.
      @(negedge clk);
      rst = 1'b0;

      // Sequential write/read of 24 addresses with random words.
      for (int i = 0; i < 24; i++) begin
         words[i] = 16'($urandom);
         acc(1'b1, 1'b1, 25'(i), words[i]);
         acc(1'b1, 1'b0, 25'(i), 16'h0000);
         chk($sformatf("seq%0d", i), rdata, words[i]);
      end

      // Reset mid-cycle while a write is pending.
      acc(1'b1, 1'b1, 25'd20, 16'hBEEF);
      acc(1'b1, 1'b0, 25'd20, 16'h0000);
      chk("beef_read", rdata, 16'hBEEF);
      @(negedge clk);
      cs    = 1'b1;
      wen   = 1'b1;
      addr  = 25'd20;
      wdata = 16'h0BAD;
      #2 rst = 1'b1;
      #1;
      chk("reset_midcycle", rdata, 16'h0000);
      @(posedge clk);
      #1;
      chk("reset_hold_edge", rdata, 16'h0000);
      @(negedge clk);
      rst  = 1'b0;
      wen  = 1'b0;
      addr = 25'd20;
      @(posedge clk);
      #1;
      chk("post_reset_read_write_dropped", rdata, 16'hBEEF);

      // Chip select: cs=0 cycles change nothing.
      acc(1'b1, 1'b1, 25'd5, 16'h1234);
      chk("cs_write_hold", rdata, 16'hBEEF);
      acc(1'b0, 1'b1, 25'd5, 16'hFFFF);
      chk("cs0_write_ignored", rdata, 16'hBEEF);
      acc(1'b0, 1'b0, 25'd5, 16'h0000);
      chk("cs0_read_ignored", rdata, 16'hBEEF);
      acc(1'b1, 1'b0, 25'd5, 16'h0000);
      chk("cs_read_back", rdata, 16'h1234);
      acc(1'bx, 1'b0, 25'd3, 16'h0000);
      chk("cs_x_no_access", rdata, 16'h1234);

      // Aliasing modulo DEPTH.
      acc(1'b1, 1'b1, 25'd3, 16'hA5A5);
      acc(1'b1, 1'b0, 25'd259, 16'h0000);
      chk("alias_259", rdata, 16'hA5A5);
      acc(1'b1, 1'b1, 25'h1FFFF07, 16'h3C3C);
      acc(1'b1, 1'b0, 25'd7, 16'h0000);
      chk("alias_high_bits", rdata, 16'h3C3C);

      // rdata holds through a write cycle (no write-through).
      acc(1'b1, 1'b1, 25'd0, 16'h0001);
      acc(1'b1, 1'b0, 25'd0, 16'h0000);
      chk("hold_read0", rdata, 16'h0001);
      prev = rdata;
      acc(1'b1, 1'b1, 25'd1, 16'h7777);
      chk("hold_on_write", rdata, 16'h0001);
      acc(1'b1, 1'b0, 25'd1, 16'h0000);
      chk("hold_readback1", rdata, 16'h7777);

      // Back-to-back writes then reads.
      acc(1'b1, 1'b1, 25'd10, 16'h1010);
      acc(1'b1, 1'b1, 25'd11, 16'h1111);
      chk("b2b_write_hold", rdata, 16'h7777);
      acc(1'b1, 1'b0, 25'd10, 16'h0000);
      chk("b2b_read10", rdata, 16'h1010);
      acc(1'b1, 1'b0, 25'd11, 16'h0000);
      chk("b2b_read11", rdata, 16'h1111);

      // Earlier sequence data survives unrelated traffic (except overwritten 0,1,3,5,7,10,11,20).
      acc(1'b1, 1'b0, 25'd22, 16'h0000);
      chk("retain22", rdata, words[22]);

      @(negedge clk);
      cs = 1'b0;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
